// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and status of the program loader.
interface imem_loader_if #(parameter int ADDR_W = 8);
   logic              start;
   logic [ADDR_W:0]   num_words;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              busy;
   logic              done;
   logic              err;
   modport master (
      output start, num_words, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
   );
   modport slave (
      input  start, num_words, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes them to
// consecutive instruction-memory addresses, holding the core until the load completes.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
   localparam logic [ADDR_W:0] NW_MAX = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [ADDR_W-1:0] word_addr_q, word_addr_d;
   logic [ADDR_W:0]   num_q, num_d;
   logic [23:0]       asm_q, asm_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              core_hold_q, core_hold_d;
   logic              err_q, err_d;

   logic start_ok, start_acc, accept, last_byte, last_word;

   assign start_ok  = bus.num_words != '0 && bus.num_words <= NW_MAX;
   assign start_acc = state_q == IDLE && bus.start && start_ok;
   assign accept    = state_q == RECV && bus.in_valid;
   assign last_byte = accept && byte_cnt_q == 2'd3;
   assign last_word = {1'b0, word_addr_q} == num_q - 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         word_addr_q <= '0;
         num_q       <= '0;
         asm_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         core_hold_q <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_addr_q <= word_addr_d;
         num_q       <= num_d;
         asm_q       <= asm_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_hold_q <= core_hold_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start_acc ? RECV : IDLE;
         RECV:    state_d = last_byte ? WRITE : RECV;
         WRITE:   state_d = last_word ? DONE : RECV;
         default: state_d = IDLE;
      endcase
   end

   // The finished word is captured on its 4th byte so it is stable through WRITE and after.
   always_comb begin
      byte_cnt_d  = start_acc ? 2'd0 : accept ? byte_cnt_q + 2'd1 : byte_cnt_q;
      word_addr_d = start_acc ? '0 : (state_q == WRITE && !last_word) ? word_addr_q + 1'b1 : word_addr_q;
      num_d       = start_acc ? bus.num_words : num_q;
      asm_d       = accept ? {asm_q[15:0], bus.in_data} : asm_q;
      mem_addr_d  = last_byte ? word_addr_q : mem_addr_q;
      mem_wdata_d = last_byte ? {asm_q, bus.in_data} : mem_wdata_q;
      core_hold_d = start_acc ? 1'b1 : state_q == DONE ? 1'b0 : core_hold_q;
      err_d       = state_q == IDLE && bus.start && !start_ok;
   end

   always_comb begin
      bus.in_ready  = state_q == RECV;
      bus.mem_we    = state_q == WRITE;
      bus.done      = state_q == DONE;
      bus.busy      = state_q != IDLE;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.core_hold = core_hold_q;
      bus.err       = err_q;
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized checks of imem_loader against a byte-list
// reference model of the expected memory writes.
module tb_imem_loader;
   localparam int AW    = 8;
   localparam int DEPTH = 256;
   typedef logic [7:0] bq_t[$];
   typedef struct {int nw; bit exp_err;} vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(AW)) bus();
   imem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] mem [DEPTH];
   int done_cnt = 0;
   int err_cnt  = 0;

   function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(int'(bus.mem_addr));
         wr_data.push_back(bus.mem_wdata);
         mem[bus.mem_addr] = bus.mem_wdata;
         check("ready_in_write", 64'(bus.in_ready), 64'd0);
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1) err_cnt++;
   end

   function automatic logic [31:0] word_of(bq_t b, int i);
      return {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
   endfunction

   function automatic logic [45:0] outs();
      return {bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err, bus.core_hold, bus.mem_addr, bus.mem_wdata};
   endfunction

   localparam logic [45:0] RESET_OUTS = {5'b0, 1'b1, 8'h00, 32'h0};

   task automatic clear();
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic do_start(input int n);
      bus.num_words = n[AW:0];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) check("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   // gap < 0 selects a random 0..2 idle cycles after each byte
   task automatic run_load(input int n, input bq_t b, input int gap);
      do_start(n);
      check("hold_busy_on_start", {62'd0, bus.core_hold, bus.busy}, 64'd3);
      foreach (b[k]) send_byte(b[k], gap < 0 ? int'($urandom_range(0, 2)) : gap);
      wait_idle();
   endtask

   task automatic verify(input int n, input bq_t b);
      check("wr_count", 64'(wr_addr.size()), 64'(n));
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
         check("wr_addr", 64'(wr_addr[i]), 64'(i));
         check("wr_data", 64'(wr_data[i]), 64'(word_of(b, i)));
      end
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("hold_released", 64'(bus.core_hold), 64'd0);
   endtask

   initial begin
      vec_t vecs[7];
      bq_t  b;
      int   hold0;
      vecs = '{'{0, 1'b1}, '{257, 1'b1}, '{511, 1'b1}, '{1, 1'b0}, '{4, 1'b0}, '{2, 1'b0}, '{0, 1'b1}};
      bus.start = 1'b0;
      bus.num_words = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;

      repeat (2) @(negedge clk);
      check("reset_outs", 64'(outs()), 64'(RESET_OUTS));
      rst = 1'b0;
      clear();
      repeat (10) @(negedge clk);
      check("idle_outs", 64'(outs()), 64'(RESET_OUTS));
      check("idle_no_writes", 64'(wr_addr.size()), 64'd0);

      foreach (vecs[v]) begin
         clear();
         hold0 = int'(bus.core_hold);
         if (vecs[v].exp_err) begin
            do_start(vecs[v].nw);
            repeat (2) @(negedge clk);
            check("err_pulse", 64'(err_cnt), 64'd1);
            check("err_no_write", 64'(wr_addr.size()), 64'd0);
            check("err_idle", {62'd0, bus.busy, bus.core_hold}, 64'(hold0));
         end else begin
            b = {};
            repeat (4 * vecs[v].nw) b.push_back(8'($urandom));
            run_load(vecs[v].nw, b, -1);
            verify(vecs[v].nw, b);
            check("no_err", 64'(err_cnt), 64'd0);
         end
      end

      b = {8'h00, 8'h22, 8'h18, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22};
      clear();
      do_start(2);
      for (int k = 0; k < 4; k++) send_byte(b[k], 0);
      check("latency_we", {31'd0, bus.mem_we, 24'd0, bus.mem_addr}, {31'd0, 1'b1, 32'd0});
      check("latency_data", 64'(bus.mem_wdata), 64'h00221820);
      for (int k = 4; k < 8; k++) send_byte(b[k], 0);
      wait_idle();
      verify(2, b);

      clear();
      run_load(2, b, 3);
      verify(2, b);

      b = {};
      repeat (12) b.push_back(8'($urandom));
      clear();
      do_start(3);
      for (int k = 0; k < 6; k++) send_byte(b[k], 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outs", 64'(outs()), 64'(RESET_OUTS));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_one_write", 64'(wr_addr.size()), 64'd1);
      check("rst_word0_kept", 64'(mem[0]), 64'(word_of(b, 0)));
      check("rst_hold", 64'(bus.core_hold), 64'd1);
      b = {};
      repeat (4) b.push_back(8'($urandom));
      clear();
      run_load(1, b, -1);
      verify(1, b);
      check("reload_mem0", 64'(mem[0]), 64'(word_of(b, 0)));

      b = {};
      for (int k = 0; k < 4 * DEPTH; k++) b.push_back(8'(k));
      clear();
      do_start(DEPTH);
      for (int k = 0; k < 4 * DEPTH; k++) begin
         send_byte(b[k], 0);
         if (k == 400) begin
            bus.num_words = 9'd1;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
         end
      end
      wait_idle();
      verify(DEPTH, b);
      check("full_last_addr", 64'(wr_addr.size() > 0 ? wr_addr[wr_addr.size()-1] : -1), 64'(DEPTH - 1));
      check("full_no_err", 64'(err_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
